id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register. Captures the Main_CTRL decode bundle plus register-file operands each cycle.
//  Detects load-use hazards: stalls IF/ID and inserts a bubble.
//  Squashes the captured instruction on a taken-branch flush from EX.
//  Sequences CPU halt on the STOP opcode (6'd63) by draining the downstream stages.
// PARAMETERS
//  DRAIN_CYCLES  3  cycles after STOP enters EX before halted asserts (covers EX, MEM, WB)
//  XLEN          32 datapath width
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     async active-low reset
//  id_valid      in   1     ID holds a real instruction
//  id_opcode     in   6     opcode of the ID instruction (STOP = 6'd63)
//  id_regwrite   in   1     decoder RegWriteEN
//  id_mem2reg    in   1     decoder Mem2RegSEL (1 = load)
//  id_memwrite   in   1     decoder MemWriteEN
//  id_beq        in   1     decoder Beq
//  id_bne        in   1     decoder Bne
//  id_regdst     in   1     decoder RegDst (1 = rd, 0 = rt)
//  id_aluctrl    in   5     decoder ALUCtrl
//  id_alusrc     in   5     decoder ALUSrc
//  id_rs,id_rt,id_rd,id_shamt  in 5 each  instruction fields
//  id_rs_data,id_rt_data,id_imm,id_pc4  in XLEN each  operands, sign-extended immediate, PC+4
//  ex_flush      in   1     branch taken in EX; squash the ID instruction
//  stall_id      out  1     hold PC and IF/ID (combinational)
//  ex_valid      out  1     EX holds a real instruction
//  ex_*          out  -     registered copies of every id_* bundle field, except id_valid and id_opcode
//  ex_dst        out  5     resolved destination register: RegDst ? rd : rt
//  ex_stop       out  1     EX holds the STOP instruction
//  halted        out  1     pipeline drained; CPU stopped
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all ex_* outputs, ex_valid, ex_stop and halted are 0; FSM is RUN; drain counter is 0.
//  Bubble definition:
//   - ex_valid=0; regwrite, memwrite, beq, bne and mem2reg = 0.
//   - Datapath fields are don't-care but are driven to 0.
//  Hazard (combinational):
//   - hz = ex_valid & ex_mem2reg & (ex_dst!=0) & id_valid & (id_rs==ex_dst | id_rt==ex_dst).
//   - stall_id = hz & ~ex_flush & (state==RUN).
//  Register update, priority order each edge:
//   1. state != RUN: bubble.
//   2. ex_flush: bubble. Flush wins over stall.
//   3. hz: bubble. ID is held upstream by stall_id.
//   4. Otherwise: capture the ID bundle, with ex_valid = id_valid.
//  Latency: 1 cycle from ID to EX.
//  A second back-to-back load-use on the same instruction cannot occur: the bubble clears hz.
//  STOP instruction:
//   - id_valid & id_opcode==63 with no flush and no stall is captured with ex_stop=1.
//   - Its regwrite and memwrite are forced to 0; decoder values for STOP are ignored.
//  FSM:
//   - RUN -> DRAIN when ex_stop=1 and ex_flush=0 at the edge. The counter loads DRAIN_CYCLES-1.
//   - A flush coincident with ex_stop squashes the STOP; FSM stays in RUN.
//   - DRAIN: counter decrements each cycle; ex_flush is ignored. DRAIN -> HALTED when counter==0.
//   - HALTED: halted=1, only bubbles are emitted. Exit only via reset.
//  stall_id is 0 outside RUN; upstream freezing is driven by halted.
//  Reset mid-DRAIN returns to RUN immediately with the counter cleared.
//  Counter width is $clog2(DRAIN_CYCLES+1).
// STRUCTURE
//  Shared package cpu_pkg:
//   - OP_STOP=6'd63, OP_RTYPE=6'd0.
//   - localparams for ALUCtrl codes (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, SRA=9).
//   - ALUSrc codes (REG=0, ZEXT=1, SEXT=2, RS_SHAMT=3, SHAMT=4).
//   - typedef ctrl_bundle_t for the eight decode fields.
//  One sub-module: load_use_detect (pure combinational hz equation), reused by the future forwarding unit.
//  FSM and register live in this file.
// TESTING
//  1. Reset mid-stream: rst_n=0 asynchronously with ex_valid=1 -> all outputs 0 before the next edge; halted=0.
//  2. Pass-through: ADD $3,$1,$2 (regdst=1, rd=3, aluctrl=0) -> next cycle ex_valid=1, ex_dst=3, ex_aluctrl=0, stall_id=0.
//  3. Load-use:
//   - Stimulus: LW $5 (rt=5, mem2reg=1) in EX; id_rs=5 in ID.
//   - Response: stall_id=1 for one cycle; next EX is a bubble; the held instruction is captured on the following cycle.
//  4. Flush beats stall: hz=1 and ex_flush=1 in the same cycle -> stall_id=0; next ex_valid=0.
//  5. No hazard to $0: LW with rt=0, then a consumer of rs=0 -> stall_id stays 0.
//  6. Halt:
//   - Stimulus: STOP in ID, DRAIN_CYCLES=3.
//   - Response: ex_stop=1 one cycle later; halted=1 exactly 3 cycles after that; ex_valid=0 from the DRAIN entry onward.
//   - Flush coincident with ex_stop -> no halt.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU/operand-select codes, decode bundle.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_STOP  = 6'd63;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_SLT = 5'd6;
  localparam logic [4:0] ALU_SLL = 5'd7;
  localparam logic [4:0] ALU_SRL = 5'd8;
  localparam logic [4:0] ALU_SRA = 5'd9;

  localparam logic [4:0] SRC_REG      = 5'd0;
  localparam logic [4:0] SRC_ZEXT     = 5'd1;
  localparam logic [4:0] SRC_SEXT     = 5'd2;
  localparam logic [4:0] SRC_RS_SHAMT = 5'd3;
  localparam logic [4:0] SRC_SHAMT    = 5'd4;

  typedef struct packed {
    logic       regwrite;
    logic       mem2reg;
    logic       memwrite;
    logic       beq;
    logic       bne;
    logic       regdst;
    logic [4:0] aluctrl;
    logic [4:0] alusrc;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX whose destination is a source of the ID instruction.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem2reg,
  input  logic [4:0] ex_dst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hz
);

  // $0 never carries a dependency, so a load targeting it is harmless
  always_comb begin
    hz = ex_valid & ex_mem2reg & (ex_dst != 5'd0) & id_valid &
         ((id_rs == ex_dst) | (id_rt == ex_dst));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch squash and STOP halt sequencing.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_RUN    | normal operation; ID bundle captured unless bubbled
//  ST_DRAIN  | STOP has left EX; bubbles only while MEM/WB empty out
//  ST_HALTED | pipeline drained, halted=1; leaves only through reset
module id_ex_stage #(
  parameter int DRAIN_CYCLES = 3,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic            id_regwrite,
  input  logic            id_mem2reg,
  input  logic            id_memwrite,
  input  logic            id_beq,
  input  logic            id_bne,
  input  logic            id_regdst,
  input  logic [4:0]      id_aluctrl,
  input  logic [4:0]      id_alusrc,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_shamt,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc4,
  input  logic            ex_flush,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_mem2reg,
  output logic            ex_memwrite,
  output logic            ex_beq,
  output logic            ex_bne,
  output logic            ex_regdst,
  output logic [4:0]      ex_aluctrl,
  output logic [4:0]      ex_alusrc,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_shamt,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc4,
  output logic [4:0]      ex_dst,
  output logic            ex_stop,
  output logic            halted
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef struct packed {
    logic            valid;
    logic            stop;
    ctrl_bundle_t    ctrl;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [4:0]      dst;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
  } ex_entry_t;

  halt_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ex_entry_t entry_q, entry_d;
  logic hz;
  logic bubble;
  logic is_stop;

  load_use_detect u_load_use_detect (
    .ex_valid   (entry_q.valid),
    .ex_mem2reg (entry_q.ctrl.mem2reg),
    .ex_dst     (entry_q.dst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hz         (hz)
  );

  // Halt sequencer next state; the drain ends when the decremented count reaches zero,
  // so halted rises exactly DRAIN_CYCLES edges after STOP entered EX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (entry_q.stop && !ex_flush) begin
          if (DRAIN_CYCLES <= 1) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Next EX entry: bubble in priority order (not running / leaving RUN, flush, hazard), else capture
  always_comb begin
    entry_d = '0;
    is_stop = id_valid && (id_opcode == OP_STOP);
    // Leaving RUN also bubbles so nothing fetched behind STOP reaches EX
    bubble  = (state_q != ST_RUN) || (state_d != ST_RUN) || ex_flush || hz;
    if (!bubble) begin
      entry_d.valid         = id_valid;
      entry_d.stop          = is_stop;
      entry_d.ctrl.regwrite = id_regwrite;
      entry_d.ctrl.mem2reg  = id_mem2reg;
      entry_d.ctrl.memwrite = id_memwrite;
      entry_d.ctrl.beq      = id_beq;
      entry_d.ctrl.bne      = id_bne;
      entry_d.ctrl.regdst   = id_regdst;
      entry_d.ctrl.aluctrl  = id_aluctrl;
      entry_d.ctrl.alusrc   = id_alusrc;
      entry_d.rs            = id_rs;
      entry_d.rt            = id_rt;
      entry_d.rd            = id_rd;
      entry_d.shamt         = id_shamt;
      entry_d.dst           = id_regdst ? id_rd : id_rt;
      entry_d.rs_data       = id_rs_data;
      entry_d.rt_data       = id_rt_data;
      entry_d.imm           = id_imm;
      entry_d.pc4           = id_pc4;
      // STOP must have no architectural side effects whatever the decoder produced
      if (is_stop) begin
        entry_d.ctrl.regwrite = 1'b0;
        entry_d.ctrl.memwrite = 1'b0;
        entry_d.ctrl.mem2reg  = 1'b0;
        entry_d.ctrl.beq      = 1'b0;
        entry_d.ctrl.bne      = 1'b0;
      end
    end
  end

  // State, drain counter and pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
    end
  end

  // Output mapping; stall is suppressed by a flush since the held instruction dies anyway
  always_comb begin
    stall_id    = hz && !ex_flush && (state_q == ST_RUN);
    halted      = (state_q == ST_HALTED);
    ex_valid    = entry_q.valid;
    ex_stop     = entry_q.stop;
    ex_regwrite = entry_q.ctrl.regwrite;
    ex_mem2reg  = entry_q.ctrl.mem2reg;
    ex_memwrite = entry_q.ctrl.memwrite;
    ex_beq      = entry_q.ctrl.beq;
    ex_bne      = entry_q.ctrl.bne;
    ex_regdst   = entry_q.ctrl.regdst;
    ex_aluctrl  = entry_q.ctrl.aluctrl;
    ex_alusrc   = entry_q.ctrl.alusrc;
    ex_rs       = entry_q.rs;
    ex_rt       = entry_q.rt;
    ex_rd       = entry_q.rd;
    ex_shamt    = entry_q.shamt;
    ex_dst      = entry_q.dst;
    ex_rs_data  = entry_q.rs_data;
    ex_rt_data  = entry_q.rt_data;
    ex_imm      = entry_q.imm;
    ex_pc4      = entry_q.pc4;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued when ID is driven
// and compared one cycle later.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [5:0]      id_opcode;
  logic            id_regwrite, id_mem2reg, id_memwrite, id_beq, id_bne, id_regdst;
  logic [4:0]      id_aluctrl, id_alusrc, id_rs, id_rt, id_rd, id_shamt;
  logic [XLEN-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic            ex_flush;
  logic            stall_id, ex_valid, ex_regwrite, ex_mem2reg, ex_memwrite, ex_beq, ex_bne;
  logic            ex_regdst, ex_stop, halted;
  logic [4:0]      ex_aluctrl, ex_alusrc, ex_rs, ex_rt, ex_rd, ex_shamt, ex_dst;
  logic [XLEN-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;

  id_ex_stage #(.DRAIN_CYCLES(3), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_regwrite(id_regwrite), .id_mem2reg(id_mem2reg), .id_memwrite(id_memwrite),
    .id_beq(id_beq), .id_bne(id_bne), .id_regdst(id_regdst),
    .id_aluctrl(id_aluctrl), .id_alusrc(id_alusrc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_flush(ex_flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_mem2reg(ex_mem2reg), .ex_memwrite(ex_memwrite),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_regdst(ex_regdst),
    .ex_aluctrl(ex_aluctrl), .ex_alusrc(ex_alusrc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_dst(ex_dst), .ex_stop(ex_stop), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            valid;
    logic            stop;
    logic            halted;
    logic            regwrite;
    logic            mem2reg;
    logic [4:0]      dst;
    logic [4:0]      aluctrl;
    logic [XLEN-1:0] rs_data;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic s, input logic h, input logic rw,
                              input logic m2r, input logic [4:0] dst, input logic [4:0] alu,
                              input logic [XLEN-1:0] rsd);
    exp_t e;
    e.valid = v; e.stop = s; e.halted = h; e.regwrite = rw; e.mem2reg = m2r;
    e.dst = dst; e.aluctrl = alu; e.rs_data = rsd;
    return e;
  endfunction

  function automatic exp_t bub(input logic h);
    return mk(1'b0, 1'b0, h, 1'b0, 1'b0, 5'd0, 5'd0, '0);
  endfunction

  task automatic set_id(input logic v, input logic [5:0] op, input logic rw, input logic m2r,
                        input logic rdst, input logic [4:0] alu, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [XLEN-1:0] rsd);
    id_valid = v; id_opcode = op; id_regwrite = rw; id_mem2reg = m2r; id_regdst = rdst;
    id_aluctrl = alu; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd;
    id_rt_data = rsd + 32'h100; id_imm = 32'hffff_fff0; id_pc4 = rsd + 32'h4;
  endtask

  // Queue the expectation for the coming edge, clock once, then pop and compare
  task automatic cycle(input string tag, input exp_t e);
    exp_t g;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      chk({tag, "_valid"},   {31'd0, ex_valid},    {31'd0, g.valid});
      chk({tag, "_stop"},    {31'd0, ex_stop},     {31'd0, g.stop});
      chk({tag, "_halted"},  {31'd0, halted},      {31'd0, g.halted});
      chk({tag, "_regwr"},   {31'd0, ex_regwrite}, {31'd0, g.regwrite});
      chk({tag, "_mem2reg"}, {31'd0, ex_mem2reg},  {31'd0, g.mem2reg});
      chk({tag, "_dst"},     {27'd0, ex_dst},      {27'd0, g.dst});
      chk({tag, "_alu"},     {27'd0, ex_aluctrl},  {27'd0, g.aluctrl});
      chk({tag, "_rsdata"},  ex_rs_data,           g.rs_data);
      if (g.valid) chk({tag, "_pc4"}, ex_pc4, g.rs_data + 32'h4);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, stall_id}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; ex_flush = 1'b0;
    id_memwrite = 1'b0; id_beq = 1'b0; id_bne = 1'b0; id_alusrc = 5'd0; id_shamt = 5'd0;
    set_id(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD $3,$1,$2
    set_id(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 32'h11);
    chk_stall("add_stall", 1'b0);
    cycle("add", mk(1, 0, 0, 1, 0, 5'd3, 5'd0, 32'h11));

    // LW $5 then consumer of $5: one stall, one bubble, then capture
    set_id(1'b1, 6'd35, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd5, 5'd0, 32'h22);
    cycle("lw5", mk(1, 0, 0, 1, 1, 5'd5, 5'd0, 32'h22));
    set_id(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd5, 5'd2, 5'd6, 32'h33);
    chk_stall("lu_stall", 1'b1);
    cycle("lu_bub", bub(1'b0));
    chk_stall("lu_release", 1'b0);
    cycle("lu_cap", mk(1, 0, 0, 1, 0, 5'd6, 5'd1, 32'h33));

    // Load-use on rt, squashed by a coincident flush
    set_id(1'b1, 6'd35, 1'b1, 1'b1, 1'b0, 5'd0, 5'd2, 5'd7, 5'd0, 32'h44);
    cycle("lw7", mk(1, 0, 0, 1, 1, 5'd7, 5'd0, 32'h44));
    set_id(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd1, 5'd7, 5'd9, 32'h55);
    ex_flush = 1'b1;
    chk_stall("fl_stall", 1'b0);
    cycle("fl_bub", bub(1'b0));
    ex_flush = 1'b0;

    // Load to $0 never stalls
    set_id(1'b1, 6'd35, 1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 32'h66);
    cycle("lw0", mk(1, 0, 0, 1, 1, 5'd0, 5'd0, 32'h66));
    set_id(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 5'd8, 32'h77);
    chk_stall("z_stall", 1'b0);
    cycle("z_cap", mk(1, 0, 0, 1, 0, 5'd8, 5'd3, 32'h77));

    // Asynchronous reset while EX holds a valid instruction
    #2; rst_n = 1'b0; #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_dst", {27'd0, ex_dst}, 32'd0);
    chk("arst_rw", {31'd0, ex_regwrite}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // STOP squashed by a flush coincident with ex_stop: no halt
    set_id(1'b1, 6'd63, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd4, 32'h88);
    cycle("stop_a", mk(1, 1, 0, 0, 0, 5'd4, 5'd0, 32'h88));
    set_id(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    ex_flush = 1'b1;
    cycle("stopfl", bub(1'b0));
    ex_flush = 1'b0;
    for (int i = 0; i < 4; i++) cycle("nohalt", bub(1'b0));

    // STOP with DRAIN_CYCLES=3: halted three edges after ex_stop, flush ignored in DRAIN
    set_id(1'b1, 6'd63, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd4, 32'h99);
    cycle("stop_b", mk(1, 1, 0, 0, 0, 5'd4, 5'd0, 32'h99));
    set_id(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle("drain1", bub(1'b0));
    ex_flush = 1'b1;
    cycle("drain2", bub(1'b0));
    ex_flush = 1'b0;
    cycle("halt", bub(1'b1));
    set_id(1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 32'haa);
    chk_stall("halt_stall", 1'b0);
    cycle("halted_bub", bub(1'b1));
    cycle("halted_hold", bub(1'b1));

    // Only reset leaves HALTED
    rst_n = 1'b0; #1;
    chk("rst_unhalt", {31'd0, halted}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_rst", mk(1, 0, 0, 1, 0, 5'd3, 5'd0, 32'haa));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
